ingress_order_arbiter: RTL and testbench

//  Shares the order book's single 32-bit input port between two word sources: the UDP input FIFO and the UART word FIFO.

---
 rtl/ingress_order_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ingress_order_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_order_arbiter.sv
// ingress_order_arbiter
//   Feeds the order book's single input port from two FWFT word sources:
//   the UDP input FIFO (src 0) and the UART word FIFO (src 1). Round-robin
//   arbitration with a burst quota, zero-word NOP filtering, and a dump
//   sequencer that drains arbitration, pulses start_dump and waits for the
//   engine to finish.
//
//   Optional feature macro: INGRESS_ARB_STATS_EN builds per-source word
//   counters; without it udp_word_count/uart_word_count are constant 0.
//
// Ports
//   clk_engine, rst_engine           clock, synchronous active-high reset
//   udp_fifo_dout/empty/rd_en        UDP FWFT source (rd_en combinational)
//   uart_fifo_dout/empty/rd_en       UART FWFT source (rd_en combinational)
//   dump_req                         dump request pulse
//   engine_busy                      order book busy
//   ob_input_valid/ob_input_data     word to engine (zero words suppressed)
//   start_dump                       one-cycle dump start
//   dump_active                      high while a dump is in progress
//   dump_timeout_err                 sticky dump timeout flag
//   nop_count                        filtered zero words, saturating
//   udp_word_count/uart_word_count   non-zero words popped per source
module ingress_order_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned DUMP_TIMEOUT = 4096,
  parameter int unsigned BUSY_WAIT    = 8
) (
  input  logic              clk_engine,
  input  logic              rst_engine,
  input  logic [DATA_W-1:0] udp_fifo_dout,
  input  logic              udp_fifo_empty,
  output logic              udp_fifo_rd_en,
  input  logic [DATA_W-1:0] uart_fifo_dout,
  input  logic              uart_fifo_empty,
  output logic              uart_fifo_rd_en,
  input  logic              dump_req,
  input  logic              engine_busy,
  output logic              ob_input_valid,
  output logic [DATA_W-1:0] ob_input_data,
  output logic              start_dump,
  output logic              dump_active,
  output logic              dump_timeout_err,
  output logic [15:0]       nop_count,
  output logic [31:0]       udp_word_count,
  output logic [31:0]       uart_word_count
);

  localparam int unsigned BCW = $clog2(BURST_LEN + 1);
  localparam int unsigned TW  = $clog2(DUMP_TIMEOUT + 1);
  localparam logic [BCW-1:0] BURST_MAX      = BCW'(BURST_LEN);
  localparam logic [TW-1:0]  BUSY_WAIT_LAST = TW'(BUSY_WAIT - 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST   = TW'(DUMP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARB,
    DUMP_START,
    DUMP_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            rr_ptr_q;
  logic [BCW-1:0]  burst_cnt_q;
  logic [BCW-1:0]  burst_next;
  logic            dump_pending_q;
  logic [TW-1:0]   wait_cnt_q;
  logic            seen_busy_q;
  logic            err_q;
  logic [15:0]     nop_q;

  logic            pop;
  logic            grant_src;
  logic [DATA_W-1:0] head;
  logic            word_nz;
  logic            dump_done;
  logic            dump_timeout;

  // Arbitration and pop datapath
  always_comb begin
    grant_src = 1'b0;
    if (!udp_fifo_empty && !uart_fifo_empty) grant_src = rr_ptr_q;
    else if (!uart_fifo_empty)               grant_src = 1'b1;

    pop = (state_q == ARB) && !engine_busy && !dump_pending_q &&
          (!udp_fifo_empty || !uart_fifo_empty);

    head    = grant_src ? uart_fifo_dout : udp_fifo_dout;
    word_nz = |head;

    // Burst count the pop would reach; a source change restarts at 1.
    burst_next = (grant_src == rr_ptr_q) ? burst_cnt_q + 1'b1 : BCW'(1);
  end

  assign udp_fifo_rd_en  = pop && !grant_src;
  assign uart_fifo_rd_en = pop &&  grant_src;
  assign ob_input_valid  = pop && word_nz;
  assign ob_input_data   = pop ? head : '0;

  // Dump sequencer next state
  always_comb begin
    state_d      = state_q;
    dump_done    = seen_busy_q && !engine_busy;
    // Phase A: busy never rose in time. Any phase: overall budget spent.
    dump_timeout = (!seen_busy_q && !engine_busy && wait_cnt_q == BUSY_WAIT_LAST) ||
                   (!dump_done && wait_cnt_q == TIMEOUT_LAST);
    unique case (state_q)
      ARB:        if (dump_pending_q && !engine_busy) state_d = DUMP_START;
      DUMP_START: state_d = DUMP_WAIT;
      DUMP_WAIT:  if (dump_done || dump_timeout) state_d = ARB;
      default:    state_d = ARB;
    endcase
  end

  assign start_dump       = (state_q == DUMP_START);
  assign dump_active      = (state_q != ARB);
  assign dump_timeout_err = err_q;
  assign nop_count        = nop_q;

  always_ff @(posedge clk_engine) begin
    if (rst_engine) begin
      state_q        <= ARB;
      rr_ptr_q       <= 1'b0;
      burst_cnt_q    <= '0;
      dump_pending_q <= 1'b0;
      wait_cnt_q     <= '0;
      seen_busy_q    <= 1'b0;
      err_q          <= 1'b0;
      nop_q          <= '0;
    end else begin
      state_q <= state_d;

      // A request in the DUMP_START cycle survives the clear.
      dump_pending_q <= dump_req || (dump_pending_q && state_q != DUMP_START);

      if (state_q == DUMP_WAIT && state_d == DUMP_WAIT) begin
        wait_cnt_q  <= wait_cnt_q + 1'b1;
        seen_busy_q <= seen_busy_q || engine_busy;
      end else begin
        wait_cnt_q  <= '0;
        seen_busy_q <= 1'b0;
      end

      if (state_q == DUMP_WAIT && dump_timeout) err_q <= 1'b1;

      if (pop) begin
        if (burst_next == BURST_MAX) begin
          rr_ptr_q    <= !grant_src;
          burst_cnt_q <= '0;
        end else begin
          rr_ptr_q    <= grant_src;
          burst_cnt_q <= burst_next;
        end
        if (!word_nz && nop_q != '1) nop_q <= nop_q + 16'd1;
      end
    end
  end

`ifdef INGRESS_ARB_STATS_EN
  logic [31:0] udp_cnt_q, uart_cnt_q;

  always_ff @(posedge clk_engine) begin
    if (rst_engine) begin
      udp_cnt_q  <= '0;
      uart_cnt_q <= '0;
    end else begin
      if (udp_fifo_rd_en && word_nz)  udp_cnt_q  <= udp_cnt_q + 32'd1;
      if (uart_fifo_rd_en && word_nz) uart_cnt_q <= uart_cnt_q + 32'd1;
    end
  end

  assign udp_word_count  = udp_cnt_q;
  assign uart_word_count = uart_cnt_q;
`else
  assign udp_word_count  = '0;
  assign uart_word_count = '0;
`endif

endmodule

// File: tb/tb_ingress_order_arbiter.sv
`timescale 1ns/1ps
module tb_ingress_order_arbiter;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] udp_fifo_dout = '0;
  logic        udp_fifo_empty = 1'b1;
  logic        udp_fifo_rd_en;
  logic [31:0] uart_fifo_dout = '0;
  logic        uart_fifo_empty = 1'b1;
  logic        uart_fifo_rd_en;
  logic        dump_req = 1'b0;
  logic        engine_busy = 1'b0;
  logic        ob_input_valid;
  logic [31:0] ob_input_data;
  logic        start_dump;
  logic        dump_active;
  logic        dump_timeout_err;
  logic [15:0] nop_count;
  logic [31:0] udp_word_count;
  logic [31:0] uart_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] udp_q[$];
  logic [31:0] uart_q[$];
  exp_t        exp_q[$];

  int start_seen = 0;
  int exp_nop = 0, exp_udp = 0, exp_uart = 0;
  int nop_base = 0, udp_base = 0, uart_base = 0;

  ingress_order_arbiter #(
    .DATA_W(32),
    .BURST_LEN(4),
    .DUMP_TIMEOUT(4096),
    .BUSY_WAIT(8)
  ) dut (
    .clk_engine(clk),
    .rst_engine(rst),
    .udp_fifo_dout(udp_fifo_dout),
    .udp_fifo_empty(udp_fifo_empty),
    .udp_fifo_rd_en(udp_fifo_rd_en),
    .uart_fifo_dout(uart_fifo_dout),
    .uart_fifo_empty(uart_fifo_empty),
    .uart_fifo_rd_en(uart_fifo_rd_en),
    .dump_req(dump_req),
    .engine_busy(engine_busy),
    .ob_input_valid(ob_input_valid),
    .ob_input_data(ob_input_data),
    .start_dump(start_dump),
    .dump_active(dump_active),
    .dump_timeout_err(dump_timeout_err),
    .nop_count(nop_count),
    .udp_word_count(udp_word_count),
    .uart_word_count(uart_word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic void refresh();
    udp_fifo_dout   = (udp_q.size() > 0) ? udp_q[0] : '0;
    udp_fifo_empty  = (udp_q.size() == 0);
    uart_fifo_dout  = (uart_q.size() > 0) ? uart_q[0] : '0;
    uart_fifo_empty = (uart_q.size() == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic src, input logic [31:0] w, input bit expect_it);
    exp_t e;
    if (src) uart_q.push_back(w);
    else     udp_q.push_back(w);
    if (expect_it) begin
      e.src  = src;
      e.data = w;
      exp_q.push_back(e);
    end
    refresh();
  endtask

  task automatic expect_pop(input logic src, input logic [31:0] w);
    exp_t e;
    e.src  = src;
    e.data = w;
    exp_q.push_back(e);
  endtask

  // FIFO model + scoreboard consumer: compare at negedge, pop after posedge.
  initial begin
    bit   pu, pa;
    exp_t e;
    forever begin
      @(negedge clk);
      if (start_dump === 1'b1) start_seen++;
      pu = (udp_fifo_rd_en === 1'b1);
      pa = (uart_fifo_rd_en === 1'b1);
      if (pu || pa) begin
        n_checks++;
        if (pu && pa) begin
          n_fail++;
          $display("FAIL one_grant: udp_rd_en=%b uart_rd_en=%b, required at most one", pu, pa);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: udp_rd_en=%b uart_rd_en=%b data=%h, required no pop", pu, pa, ob_input_data);
        end else begin
          e = exp_q.pop_front();
          if (e.data == 0) exp_nop++;
          else if (e.src) exp_uart++;
          else exp_udp++;
          n_checks++;
          if (pa !== e.src) begin
            n_fail++;
            $display("FAIL grant_src: got src %0d, required src %0d (word %h)", pa, e.src, e.data);
          end
          n_checks++;
          if (ob_input_data !== e.data) begin
            n_fail++;
            $display("FAIL ob_data: got %h, required %h", ob_input_data, e.data);
          end
          n_checks++;
          if (ob_input_valid !== (e.data != 0)) begin
            n_fail++;
            $display("FAIL ob_valid: got %b, required %b for word %h", ob_input_valid, (e.data != 0), e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (pu && udp_q.size() > 0)  void'(udp_q.pop_front());
      if (pa && uart_q.size() > 0) void'(uart_q.pop_front());
      refresh();
    end
  end

  task automatic do_reset();
    rst         = 1'b1;
    engine_busy = 1'b0;
    dump_req    = 1'b0;
    udp_q.delete();
    uart_q.delete();
    exp_q.delete();
    refresh();
    step();
    step();
    rst       = 1'b0;
    nop_base  = exp_nop;
    udp_base  = exp_udp;
    uart_base = exp_uart;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int eu, ea;
    for (int i = 0; i < budget; i++) begin
      if (udp_q.size() == 0 && uart_q.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    n_checks++;
    if (udp_q.size() != 0 || uart_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: udp_left=%0d uart_left=%0d exp_left=%0d, required 0 within %0d cycles",
               name, udp_q.size(), uart_q.size(), exp_q.size(), budget);
    end
    n_checks++;
    if (nop_count !== 16'(exp_nop - nop_base)) begin
      n_fail++;
      $display("FAIL %s_nop_count: got %0d, required %0d", name, nop_count, exp_nop - nop_base);
    end
`ifdef INGRESS_ARB_STATS_EN
    eu = exp_udp - udp_base;
    ea = exp_uart - uart_base;
`else
    eu = 0;
    ea = 0;
`endif
    n_checks++;
    if (udp_word_count !== 32'(eu) || uart_word_count !== 32'(ea)) begin
      n_fail++;
      $display("FAIL %s_stats: got udp=%0d uart=%0d, required udp=%0d uart=%0d",
               name, udp_word_count, uart_word_count, eu, ea);
    end
  endtask

  task automatic wait_start(input string name);
    bool_found: begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (start_dump === 1'b1) disable bool_found;
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s_start_dump: got no pulse in 40 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    refresh();
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({udp_fifo_rd_en, uart_fifo_rd_en, ob_input_valid, start_dump, dump_active, dump_timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd_en=%b%b valid=%b start=%b active=%b err=%b, required all 0",
               udp_fifo_rd_en, uart_fifo_rd_en, ob_input_valid, start_dump, dump_active, dump_timeout_err);
    end
    n_checks++;
    if (ob_input_data !== 32'h0 || nop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h nop=%0d, required 0 and 0", ob_input_data, nop_count);
    end
    n_checks++;
    if (udp_word_count !== 32'h0 || uart_word_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_stats: got udp=%0d uart=%0d, required 0 and 0", udp_word_count, uart_word_count);
    end
    do_reset();
  endtask

  task automatic test_single_source();
    logic [31:0] w [3];
    w[0] = 32'h11111111;
    w[1] = 32'h22222222;
    w[2] = 32'h33333333;
    do_reset();
    for (int i = 0; i < 3; i++) load(1'b0, w[i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (udp_fifo_rd_en !== 1'b1 || ob_input_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_consecutive[%0d]: got rd_en=%b valid=%b, required 1 and 1", i, udp_fifo_rd_en, ob_input_valid);
      end
    end
    wait_drain("single", 20);
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load(1'b0, 32'hA000_0000 + 32'(i), 1'b0);
      load(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) expect_pop(1'b0, 32'hA000_0000 + 32'(r * 4 + i));
      for (int i = 0; i < 4; i++) expect_pop(1'b1, 32'hB000_0000 + 32'(r * 4 + i));
    end
    wait_drain("burst", 40);
  endtask

  task automatic test_nop();
    do_reset();
    load(1'b0, 32'h0000_0000, 1'b1);
    load(1'b0, 32'h0102_0304, 1'b1);
    wait_drain("nop", 20);
    n_checks++;
    if (nop_count !== 16'd1) begin
      n_fail++;
      $display("FAIL nop_total: got %0d, required 1", nop_count);
    end
  endtask

  task automatic test_busy_block();
    do_reset();
    engine_busy = 1'b1;
    load(1'b0, 32'hC0DE_0001, 1'b1);
    load(1'b0, 32'hC0DE_0002, 1'b1);
    load(1'b1, 32'hD00D_0001, 1'b1);
    load(1'b1, 32'hD00D_0002, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (udp_fifo_rd_en !== 1'b0 || uart_fifo_rd_en !== 1'b0 || ob_input_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: got rd_en=%b%b valid=%b, required 0", i, udp_fifo_rd_en, uart_fifo_rd_en, ob_input_valid);
      end
    end
    step();
    engine_busy = 1'b0;
    wait_drain("busy", 20);
  endtask

  task automatic test_dump_coalesce();
    int base;
    do_reset();
    base = start_seen;
    for (int i = 0; i < 8; i++) load(1'b0, 32'hE000_0000 + 32'(i + 1), 1'b1);
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start("dump");
    n_checks++;
    if (udp_q.size() != 6) begin
      n_fail++;
      $display("FAIL dump_pops_stop: got %0d words left at start_dump, required 6", udp_q.size());
    end
    step();
    engine_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (udp_fifo_rd_en !== 1'b0 || dump_active !== 1'b1) begin
        n_fail++;
        $display("FAIL dump_wait[%0d]: got rd_en=%b active=%b, required 0 and 1", i, udp_fifo_rd_en, dump_active);
      end
    end
    step();
    engine_busy = 1'b0;
    wait_drain("dump", 40);
    n_checks++;
    if (start_seen - base != 1) begin
      n_fail++;
      $display("FAIL dump_single_pulse: got %0d start_dump cycles, required 1", start_seen - base);
    end
    n_checks++;
    if (dump_active !== 1'b0 || dump_timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_end: got active=%b err=%b, required 0 and 0", dump_active, dump_timeout_err);
    end
  endtask

  task automatic test_busy_timeout();
    int n_wait;
    do_reset();
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start("timeout");
    n_wait = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dump_active !== 1'b1) break;
      n_wait++;
    end
    n_checks++;
    if (n_wait != 8) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d DUMP_WAIT cycles, required 8", n_wait);
    end
    n_checks++;
    if (dump_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err_set: got %b, required 1", dump_timeout_err);
    end
    step();
    load(1'b0, 32'h5555_0001, 1'b1);
    load(1'b0, 32'h5555_0002, 1'b1);
    wait_drain("timeout_resume", 20);
    n_checks++;
    if (dump_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err_sticky: got %b, required 1", dump_timeout_err);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (dump_timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_cleared: got %b, required 0", dump_timeout_err);
    end
  endtask

  task automatic test_reset_mid_dump();
    int base;
    do_reset();
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start("mid");
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (dump_active !== 1'b0 || start_dump !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got active=%b start=%b, required 0 and 0", dump_active, start_dump);
    end
    rst  = 1'b0;
    base = start_seen;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (start_seen - base != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_reissue: got %0d start_dump cycles, required 0", start_seen - base);
    end
  endtask

  initial begin
    refresh();
    test_reset();
    test_single_source();
    test_burst();
    test_nop();
    test_busy_block();
    test_dump_coalesce();
    test_busy_timeout();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
